// File: rtl/sparse_vector_generator_if.sv
// Bus bundle between the sparse vector generator and its neighbours:
// frame tables and start request in, gathered vectors and status out.
interface sparse_vector_generator_if #(
  parameter int IN_CHANNELS      = 3,
  parameter int IN_SIZE          = 32,
  parameter int FILTERS          = 48,
  parameter int KER_SIZE         = 3,
  parameter int STRIDE           = 1,
  parameter int PADDING          = 1,
  parameter int NON_ZERO_WEIGHTS = 27,
  parameter int BIT_SIZE         = 16
);
  localparam int OUT_SIZE = (IN_SIZE - KER_SIZE + 2 * PADDING) / STRIDE + 1;
  localparam int CW       = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KW       = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
  localparam int EW       = CW + 2 * KW;
  localparam int WIW      = $clog2(NON_ZERO_WEIGHTS) + 1;

  logic [IN_CHANNELS*IN_SIZE*IN_SIZE*BIT_SIZE-1:0] fmap;
  logic [NON_ZERO_WEIGHTS*EW-1:0]                  idx_table;
  logic [NON_ZERO_WEIGHTS*FILTERS*BIT_SIZE-1:0]    weight_table;
  logic                                            start;
  logic                                            ready;
  logic [OUT_SIZE*OUT_SIZE*BIT_SIZE-1:0]           activations;
  logic [FILTERS*BIT_SIZE-1:0]                     weights;
  logic [WIW-1:0]                                  weight_index;
  logic                                            vec_valid;
  logic                                            frame_done;
  logic                                            idx_err;

  modport master (
    output fmap, idx_table, weight_table, start,
    input  ready, activations, weights, weight_index, vec_valid, frame_done, idx_err
  );

  modport slave (
    input  fmap, idx_table, weight_table, start,
    output ready, activations, weights, weight_index, vec_valid, frame_done, idx_err
  );
endinterface

// File: rtl/sparse_vector_generator.sv
// Sparse vector generator: latches a feature map plus sparse weight table and,
// for every non-zero weight entry, emits the padded/strided activation window
// of the selected channel and kernel offset together with the per-filter
// weight row. Two-stage pipeline: decode (entry select) then gather.
module sparse_vector_generator #(
  parameter int IN_CHANNELS      = 3,
  parameter int IN_SIZE          = 32,
  parameter int FILTERS          = 48,
  parameter int KER_SIZE         = 3,
  parameter int STRIDE           = 1,
  parameter int PADDING          = 1,
  parameter int NON_ZERO_WEIGHTS = 27,
  parameter int BIT_SIZE         = 16
) (
  input logic                     clk,
  input logic                     rst,
  sparse_vector_generator_if.slave bus
);
  localparam int OUT_SIZE = (IN_SIZE - KER_SIZE + 2 * PADDING) / STRIDE + 1;
  localparam int CW       = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KW       = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
  localparam int EW       = CW + 2 * KW;
  localparam int WIW      = $clog2(NON_ZERO_WEIGHTS) + 1;
  localparam int KIW      = (NON_ZERO_WEIGHTS > 1) ? $clog2(NON_ZERO_WEIGHTS) : 1;
  localparam int PIX      = IN_SIZE * IN_SIZE;
  localparam int PIW      = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int OPIX     = OUT_SIZE * OUT_SIZE;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [WIW-1:0] LAST_IDX = WIW'(NON_ZERO_WEIGHTS - 1);

  // Latched frame
  logic [IN_CHANNELS-1:0][PIX-1:0][BIT_SIZE-1:0]          fmap_r;
  logic [NON_ZERO_WEIGHTS-1:0][EW-1:0]                    idx_r;
  logic [NON_ZERO_WEIGHTS-1:0][FILTERS-1:0][BIT_SIZE-1:0] wt_r;

  // Control
  logic [0:0]     state_r;
  logic [WIW-1:0] cnt_r;
  logic           last_s;
  logic           ready_s;
  logic           accept_s;

  // Stage 1 (decode) combinational selects
  logic [EW-1:0]                         entry_s;
  logic [CW-1:0]                         c_s;
  logic [KW-1:0]                         ky_s;
  logic [KW-1:0]                         kx_s;
  logic                                  bad_s;
  logic [PIX-1:0][BIT_SIZE-1:0]          plane_s;
  logic [FILTERS-1:0][BIT_SIZE-1:0]      wrow_s;

  // Stage 1 registers: the selected channel plane and weight row travel with
  // the entry, so a back-to-back frame may overwrite the latched tables while
  // the previous frame's last entry is still being gathered.
  logic                                  s1_valid_r;
  logic [WIW-1:0]                        s1_k_r;
  logic [KW-1:0]                         s1_ky_r;
  logic [KW-1:0]                         s1_kx_r;
  logic                                  s1_bad_r;
  logic [PIX-1:0][BIT_SIZE-1:0]          s1_plane_r;
  logic [FILTERS-1:0][BIT_SIZE-1:0]      s1_wrow_r;

  // Stage 2 (gather)
  logic [OPIX-1:0][BIT_SIZE-1:0]         act_s;
  logic [OPIX-1:0][BIT_SIZE-1:0]         act_r;
  logic [FILTERS-1:0][BIT_SIZE-1:0]      wts_r;
  logic [WIW-1:0]                        widx_r;
  logic                                  valid_r;
  logic                                  done_r;
  logic                                  err_r;

  assign last_s   = (cnt_r == LAST_IDX);
  assign ready_s  = (state_r == ST_IDLE) || ((state_r == ST_STREAM) && last_s);
  assign accept_s = bus.start && ready_s;

  // Capture the frame tables whenever a start request is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fmap_r <= '0;
      idx_r  <= '0;
      wt_r   <= '0;
    end else if (accept_s) begin
      fmap_r <= bus.fmap;
      idx_r  <= bus.idx_table;
      wt_r   <= bus.weight_table;
    end
  end

  // Frame state and decode counter; a start on the last entry chains frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else if (accept_s) begin
      state_r <= ST_STREAM;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_STREAM: begin
          if (last_s) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + WIW'(1);
          end
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Decode the current entry and select its channel plane and weight row
  always_comb begin
    entry_s = idx_r[cnt_r[KIW-1:0]];
    c_s     = entry_s[EW-1 -: CW];
    ky_s    = entry_s[KW +: KW];
    kx_s    = entry_s[KW-1:0];
    bad_s   = (int'(c_s) >= IN_CHANNELS) || (int'(ky_s) >= KER_SIZE) ||
              (int'(kx_s) >= KER_SIZE);
    if (bad_s) begin
      plane_s = '0;
      wrow_s  = '0;
    end else begin
      plane_s = fmap_r[c_s];
      wrow_s  = wt_r[cnt_r[KIW-1:0]];
    end
  end

  // Stage 1 pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_k_r     <= '0;
      s1_ky_r    <= '0;
      s1_kx_r    <= '0;
      s1_bad_r   <= 1'b0;
      s1_plane_r <= '0;
      s1_wrow_r  <= '0;
    end else begin
      s1_valid_r <= (state_r == ST_STREAM);
      s1_k_r     <= cnt_r;
      s1_ky_r    <= ky_s;
      s1_kx_r    <= kx_s;
      s1_bad_r   <= bad_s;
      s1_plane_r <= plane_s;
      s1_wrow_r  <= wrow_s;
    end
  end

  // Window gather: signed 32-bit indices cover the full padded range, and
  // anything outside the map reads as zero padding
  always_comb begin
    int iy;
    int ix;
    logic [PIW-1:0] pidx;
    act_s = '0;
    iy    = 0;
    ix    = 0;
    pidx  = '0;
    for (int oy = 0; oy < OUT_SIZE; oy++) begin
      for (int ox = 0; ox < OUT_SIZE; ox++) begin
        iy = oy * STRIDE + int'(s1_ky_r) - PADDING;
        ix = ox * STRIDE + int'(s1_kx_r) - PADDING;
        if ((iy >= 0) && (iy < IN_SIZE) && (ix >= 0) && (ix < IN_SIZE)) begin
          pidx = PIW'(iy * IN_SIZE + ix);
          act_s[oy*OUT_SIZE+ox] = s1_plane_r[pidx];
        end else begin
          act_s[oy*OUT_SIZE+ox] = '0;
        end
      end
    end
  end

  // Stage 2 output register; outputs are zero whenever no vector is presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_r   <= '0;
      wts_r   <= '0;
      widx_r  <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else if (s1_valid_r) begin
      act_r   <= act_s;
      wts_r   <= s1_wrow_r;
      widx_r  <= s1_k_r;
      valid_r <= 1'b1;
      done_r  <= (s1_k_r == LAST_IDX);
    end else begin
      act_r   <= '0;
      wts_r   <= '0;
      widx_r  <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end
  end

  // Sticky out-of-range flag, raised together with the offending vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (s1_valid_r && s1_bad_r) begin
      err_r <= 1'b1;
    end
  end

  assign bus.ready        = ready_s;
  assign bus.activations  = act_r;
  assign bus.weights      = wts_r;
  assign bus.weight_index = widx_r;
  assign bus.vec_valid    = valid_r;
  assign bus.frame_done   = done_r;
  assign bus.idx_err      = err_r;
endmodule
